// File: rtl/hub75_pkg.sv
// -----------------------------------------------------------------------------
// hub75_pkg
// Shared definitions for the display pipeline. This file holds the defaults for
// the WS2812 transmitter, the GRB pixel field offsets, the transmitter state
// encoding and a helper that returns the high time of one serial bit.
// -----------------------------------------------------------------------------
package hub75_pkg;

  // Default WS2812 timing, in sys_clk cycles at 50 MHz.
  localparam int WS_NUM_LEDS  = 64;
  localparam int WS_ADDR_W    = 8;
  localparam int WS_BASE_ADDR = 0;
  localparam int WS_T_BIT     = 63;    // 1.25 us per bit
  localparam int WS_T0H       = 20;    // high time of a 0 bit
  localparam int WS_T1H       = 40;    // high time of a 1 bit
  localparam int WS_T_RST     = 2600;  // > 50 us latch period

  // Pixel word layout. Green goes out first, so it sits in the top byte.
  localparam int PIX_W     = 24;
  localparam int PIX_G_LSB = 16;
  localparam int PIX_R_LSB = 8;
  localparam int PIX_B_LSB = 0;

  // Transmitter states, in frame order.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREFETCH = 3'd1,
    ST_LOAD     = 3'd2,
    ST_SEND     = 3'd3,
    ST_LATCH    = 3'd4
  } ws_state_t;

  // Number of high cycles at the start of a bit slot.
  function automatic int ws_high_cycles(input logic bit_val, input int t0h,
                                        input int t1h);
    return bit_val ? t1h : t0h;
  endfunction

endpackage

// File: rtl/ws2812_bit_gen.sv
// -----------------------------------------------------------------------------
// ws2812_bit_gen
// Produces one WS2812 bit slot of T_BIT cycles. The line is high for T1H or T0H
// cycles (depending on i_bit) and low for the rest of the slot.
//
// Ports:
//   i_clk      : system clock
//   i_rst      : synchronous active-high reset, forces the line low
//   i_start    : starts a slot on the next cycle. It may arrive in the same
//                cycle as o_bit_done so that slots run back to back.
//   i_bit      : bit value. It must stay stable for the whole slot; the parent
//                keeps it in the MSB of its shift register.
//   o_dout     : registered serial waveform
//   o_bit_done : high in the last cycle of a slot
// -----------------------------------------------------------------------------
module ws2812_bit_gen
  import hub75_pkg::*;
#(
  parameter int T_BIT = WS_T_BIT,
  parameter int T0H   = WS_T0H,
  parameter int T1H   = WS_T1H
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_bit,
  output logic o_dout,
  output logic o_bit_done
);

  localparam int CW = (T_BIT > 1) ? $clog2(T_BIT) : 1;

  logic [CW-1:0] r_cyc;
  logic          r_active;
  logic          r_dout;
  logic [CW-1:0] w_cyc_nxt;

  assign w_cyc_nxt  = r_cyc + CW'(1);
  assign o_bit_done = r_active && (r_cyc == CW'(T_BIT - 1));
  assign o_dout     = r_dout;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cyc    <= '0;
      r_active <= 1'b0;
      r_dout   <= 1'b0;
    end else if (i_start) begin
      // Cycle 0 of a slot is always high because T0H >= 1.
      r_cyc    <= '0;
      r_active <= 1'b1;
      r_dout   <= 1'b1;
    end else if (o_bit_done) begin
      r_cyc    <= '0;
      r_active <= 1'b0;
      r_dout   <= 1'b0;
    end else if (r_active) begin
      // dout is registered, so it is computed from the count of the next cycle.
      r_cyc  <= w_cyc_nxt;
      r_dout <= (int'(w_cyc_nxt) < ws_high_cycles(i_bit, T0H, T1H));
    end
  end

endmodule

// File: rtl/ws2812_tx.sv
// -----------------------------------------------------------------------------
// ws2812_tx
// Streams NUM_LEDS GRB words from RAM to a WS2812 chain. Each frame_start makes
// the block fetch the pixels, send them MSB first, and then hold the line low
// for T_RST cycles.
// Timing constraint: 0 < T0H < T1H < T_BIT - 2, NUM_LEDS >= 1.
//
// Ports:
//   sys_clk     : system clock
//   rst         : synchronous active-high reset. It aborts any frame in progress.
//   frame_start : one-cycle start pulse. While busy, one request is queued.
//   np_raddr    : RAM read address. It holds its value between reads.
//   np_re       : RAM read strobe. np_rdata is valid one cycle later.
//   np_rdata    : pixel word {G, R, B}
//   dout        : serial line to the LED chain
//   busy        : high from frame acceptance to the end of the latch period
//   frame_done  : one-cycle pulse on the last latch cycle
//   dbg_state   : current state of the control FSM
//
// Handshake: the RAM port has no backpressure. Each np_re cycle is exactly one
// read of np_raddr, and the word is sampled from np_rdata in the following cycle.
// -----------------------------------------------------------------------------
module ws2812_tx
  import hub75_pkg::*;
#(
  parameter int NUM_LEDS  = WS_NUM_LEDS,
  parameter int ADDR_W    = WS_ADDR_W,
  parameter int BASE_ADDR = WS_BASE_ADDR,
  parameter int T_BIT     = WS_T_BIT,
  parameter int T0H       = WS_T0H,
  parameter int T1H       = WS_T1H,
  parameter int T_RST     = WS_T_RST
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              frame_start,
  output logic [ADDR_W-1:0] np_raddr,
  output logic              np_re,
  input  logic [23:0]       np_rdata,
  output logic              dout,
  output logic              busy,
  output logic              frame_done,
  output ws_state_t         dbg_state
);

  localparam int PW = $clog2(NUM_LEDS + 1);
  localparam int LW = (T_RST > 1) ? $clog2(T_RST) : 1;

  ws_state_t         r_state;
  logic              r_pending;
  logic              r_busy;
  logic              r_done;
  logic              r_re;
  logic [ADDR_W-1:0] r_raddr;
  logic              r_cap;       // np_rdata carries a prefetched pixel this cycle
  logic [23:0]       r_sh;        // current pixel; bit [23] is the bit on the line
  logic [23:0]       r_nxt;       // next pixel, fetched during bit 23
  logic [4:0]        r_bit_cnt;
  logic [PW-1:0]     r_pix;
  logic [LW-1:0]     r_lat;

  logic w_bit_done;
  logic w_dout;
  logic w_last_bit;
  logic w_last_pix;
  logic w_start;

  assign w_last_bit = (r_bit_cnt == 5'd0);
  assign w_last_pix = (r_pix == PW'(NUM_LEDS - 1));

  // A new slot starts right after LOAD. After that, a new slot starts at the
  // end of every slot except the last bit of the last pixel, so that the slots
  // follow each other with no gap.
  assign w_start = (r_state == ST_LOAD) ||
                   ((r_state == ST_SEND) && w_bit_done && !(w_last_bit && w_last_pix));

  ws2812_bit_gen #(
    .T_BIT (T_BIT),
    .T0H   (T0H),
    .T1H   (T1H)
  ) u_bit_gen (
    .i_clk      (sys_clk),
    .i_rst      (rst),
    .i_start    (w_start),
    .i_bit      (r_sh[23]),
    .o_dout     (w_dout),
    .o_bit_done (w_bit_done)
  );

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pending <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_re      <= 1'b0;
      r_raddr   <= ADDR_W'(BASE_ADDR);
      r_cap     <= 1'b0;
      r_sh      <= '0;
      r_nxt     <= '0;
      r_bit_cnt <= '0;
      r_pix     <= '0;
      r_lat     <= '0;
    end else begin
      r_re   <= 1'b0;
      r_done <= 1'b0;
      r_cap  <= r_re;
      if (r_cap) r_nxt <= np_rdata;
      // Requests that arrive while a frame runs are merged into one.
      if (frame_start && (r_state != ST_IDLE)) r_pending <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (frame_start || r_pending) begin
            r_re      <= 1'b1;
            r_raddr   <= ADDR_W'(BASE_ADDR);
            r_busy    <= 1'b1;
            r_pending <= 1'b0;
            r_state   <= ST_PREFETCH;
          end
        end
        ST_PREFETCH: r_state <= ST_LOAD;
        ST_LOAD: begin
          r_sh      <= np_rdata;
          r_bit_cnt <= 5'd23;
          r_pix     <= '0;
          r_state   <= ST_SEND;
          // Pixel 1 is read during bit 23 of pixel 0.
          if (NUM_LEDS > 1) begin
            r_re    <= 1'b1;
            r_raddr <= r_raddr + ADDR_W'(1);
          end
        end
        ST_SEND: begin
          if (w_bit_done) begin
            if (w_last_bit) begin
              if (w_last_pix) begin
                r_lat   <= '0;
                r_done  <= (T_RST == 1);
                r_state <= ST_LATCH;
              end else begin
                r_sh      <= r_nxt;
                r_bit_cnt <= 5'd23;
                r_pix     <= r_pix + PW'(1);
                // Read the pixel after the one that starts now, if there is one.
                if (int'(r_pix) + 2 < NUM_LEDS) begin
                  r_re    <= 1'b1;
                  r_raddr <= r_raddr + ADDR_W'(1);
                end
              end
            end else begin
              r_sh      <= {r_sh[22:0], 1'b0};
              r_bit_cnt <= r_bit_cnt - 5'd1;
            end
          end
        end
        ST_LATCH: begin
          if (int'(r_lat) == T_RST - 1) begin
            // If a request is queued, busy stays high through the IDLE cycle
            // that starts the next frame.
            r_busy    <= r_pending || frame_start;
            r_pending <= r_pending || frame_start;
            r_state   <= ST_IDLE;
          end else begin
            r_lat  <= r_lat + LW'(1);
            r_done <= (int'(r_lat) + 2 == T_RST);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign np_raddr   = r_raddr;
  assign np_re      = r_re;
  assign dout       = w_dout;
  assign busy       = r_busy;
  assign frame_done = r_done;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_ws2812_tx.sv
module tb_ws2812_tx;
  import hub75_pkg::*;

  localparam int NL    = 2;
  localparam int AW    = 8;
  localparam int BASE  = 4;
  localparam int TB    = 10;
  localparam int T0    = 3;
  localparam int T1    = 6;
  localparam int TR    = 20;
  localparam int FR    = 2 + NL * 24 * TB + TR;  // frame_start cycle -> frame_done cycle
  localparam int FIRST = 3;                      // first high cycle after frame_start
  localparam int MAXC  = 40000;

  // Codes for the signals that literal checks refer to.
  localparam int S_DOUT = 0, S_BUSY = 1, S_DONE = 2, S_RE = 3, S_ADDR = 4, S_STATE = 5, S_RECNT = 6;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_start = 1'b0;
  logic [AW-1:0] np_raddr;
  logic          np_re;
  logic [23:0]   np_rdata;
  logic          dout, busy, frame_done;
  ws_state_t     dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ws2812_tx #(
    .NUM_LEDS(NL), .ADDR_W(AW), .BASE_ADDR(BASE), .T_BIT(TB),
    .T0H(T0), .T1H(T1), .T_RST(TR)
  ) dut (
    .sys_clk(clk), .rst(rst), .frame_start(frame_start),
    .np_raddr(np_raddr), .np_re(np_re), .np_rdata(np_rdata),
    .dout(dout), .busy(busy), .frame_done(frame_done), .dbg_state(dbg_state)
  );

  logic [23:0] ram [0:255];
  always @(posedge clk) if (np_re) np_rdata <= ram[np_raddr];

  // ---------------- model and scoreboard ----------------
  bit          exp_dout [MAXC];
  bit          exp_busy [MAXC];
  bit          exp_done [MAXC];
  logic [23:0] exp_q [$];
  logic [7:0]  addr_q [$];
  int          last_start = -1;
  int          last_end = -1;

  typedef struct {
    int          c;
    int          sig;
    logic [31:0] v;
  } lit_t;
  lit_t lit_q [$];

  int   errors = 0;
  int   checks = 0;
  bit   chk_en = 1'b0;
  bit   end_req = 1'b0;
  bit   end_done = 1'b0;
  int   re_cnt = 0;
  int   hi_len = 0;
  int   nbits = 0;
  logic [23:0] acc = '0;
  logic dec_bit;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  // A frame accepted in cycle t0 follows from the timing rules: bit k of the
  // frame occupies cycles t0+FIRST+k*TB onwards and is high for T1 or T0
  // cycles. busy covers t0+1..t0+FR, and frame_done is set at t0+FR.
  task automatic model_frame(input int t0);
    logic [23:0] w;
    for (int p = 0; p < NL; p++) begin
      w = ram[BASE + p];
      exp_q.push_back(w);
      addr_q.push_back(8'(BASE + p));
      for (int i = 0; i < 24; i++) begin
        int s, h;
        s = t0 + FIRST + (p * 24 + i) * TB;
        h = w[23 - i] ? T1 : T0;
        for (int j = 0; j < h; j++) if (s + j < MAXC) exp_dout[s + j] = 1'b1;
      end
    end
    for (int k = t0 + 1; k <= t0 + FR; k++) if (k < MAXC) exp_busy[k] = 1'b1;
    if (t0 + FR < MAXC) exp_done[t0 + FR] = 1'b1;
    last_start = t0;
    last_end   = t0 + FR;
  endtask

  task automatic model_start(input int c);
    if (c > last_end) model_frame(c);
    else if (c >= last_start) begin
      // Queued request: accepted in the cycle after frame_done, busy stays high.
      if (last_end + 1 < MAXC) exp_busy[last_end + 1] = 1'b1;
      model_frame(last_end + 1);
    end
    // A request while one is already queued is dropped.
  endtask

  task automatic model_reset(input int r);
    for (int k = r + 1; k < MAXC; k++) begin
      exp_dout[k] = 1'b0;
      exp_busy[k] = 1'b0;
      exp_done[k] = 1'b0;
    end
    exp_q.delete();
    addr_q.delete();
    last_start = -1;
    last_end   = -1;
  endtask

  task automatic lit(input int c, input int sig, input logic [31:0] v);
    lit_t e;
    e.c = c; e.sig = sig; e.v = v;
    lit_q.push_back(e);
  endtask

  // Single compare process: model, literal checks, address checks, pulse decoder.
  always @(negedge clk) begin
    if (chk_en && cyc < MAXC) begin
      chk("dout", dout, exp_dout[cyc]);
      chk("busy", busy, exp_busy[cyc]);
      chk("frame_done", frame_done, exp_done[cyc]);
      if (np_re === 1'b1) begin
        re_cnt++;
        if (addr_q.size() == 0) chk("np_re_unexpected", np_re, 0);
        else chk("np_raddr", np_raddr, addr_q.pop_front());
      end
      for (int i = lit_q.size() - 1; i >= 0; i--) begin
        if (lit_q[i].c == cyc) begin
          case (lit_q[i].sig)
            S_DOUT:  chk("lit_dout", dout, lit_q[i].v);
            S_BUSY:  chk("lit_busy", busy, lit_q[i].v);
            S_DONE:  chk("lit_frame_done", frame_done, lit_q[i].v);
            S_RE:    chk("lit_np_re", np_re, lit_q[i].v);
            S_ADDR:  chk("lit_np_raddr", np_raddr, lit_q[i].v);
            S_STATE: chk("lit_state", 32'(dbg_state), lit_q[i].v);
            default: chk("lit_re_count", re_cnt, lit_q[i].v);
          endcase
          lit_q.delete(i);
        end
      end
      // Decode the pulse widths back into GRB words.
      if (rst) begin
        hi_len = 0; nbits = 0; acc = '0;
      end else if (dout === 1'b1) begin
        hi_len++;
      end else if (hi_len > 0) begin
        dec_bit = (hi_len == T1);
        if (hi_len != T1 && hi_len != T0) chk("pulse_width", hi_len, (hi_len > 4) ? T1 : T0);
        acc = {acc[22:0], dec_bit};
        nbits++;
        hi_len = 0;
        if (nbits == 24) begin
          if (exp_q.size() == 0) chk("pixel_extra", exp_q.size(), 1);
          else chk("pixel_word", acc, exp_q.pop_front());
          nbits = 0;
        end
      end
    end
    if (end_req && !end_done) begin
      chk("pixels_left", exp_q.size(), 0);
      chk("reads_left", addr_q.size(), 0);
      chk("lits_left", lit_q.size(), 0);
      end_done = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(output int c);
    @(posedge clk);
    #1;
    frame_start = 1'b1;
    c = cyc;
    model_start(c);
    @(posedge clk);
    #1;
    frame_start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c, c2, r;
    for (int i = 0; i < 256; i++) ram[i] = 24'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    // Reset state.
    lit(cyc, S_DOUT, 0); lit(cyc, S_BUSY, 0); lit(cyc, S_DONE, 0);
    lit(cyc, S_RE, 0); lit(cyc, S_ADDR, BASE); lit(cyc, S_STATE, 32'(ST_IDLE));

    // Idle: no activity for 1000 cycles.
    lit(cyc + 1000, S_RECNT, 0);
    wait_until(cyc + 1001);

    // Basic frame.
    ram[4] = 24'hFF0000; ram[5] = 24'h000001;
    pulse_start(c);
    lit(c + 1, S_RE, 1); lit(c + 1, S_ADDR, 4); lit(c + 2, S_RE, 0);
    lit(c + 3, S_RE, 1); lit(c + 3, S_ADDR, 5);
    lit(c + FIRST + 5, S_DOUT, 1);        lit(c + FIRST + 6, S_DOUT, 0);
    lit(c + FIRST + 82, S_DOUT, 1);       lit(c + FIRST + 83, S_DOUT, 0);
    lit(c + FIRST + 475, S_DOUT, 1);      lit(c + FIRST + 476, S_DOUT, 0);
    lit(c + FIRST + 480, S_DOUT, 0);      lit(c + FIRST + 480, S_BUSY, 1);
    lit(c + 501, S_DONE, 0); lit(c + 502, S_DONE, 1);
    lit(c + 503, S_BUSY, 0); lit(c + 503, S_DONE, 0);
    lit(c + 505, S_RECNT, 2);
    wait_until(c + FR + 5);

    // Pixel boundary: bit 0 of pixel 0 and bit 23 of pixel 1 are both 1.
    ram[4] = 24'h000001; ram[5] = 24'h800000;
    pulse_start(c);
    lit(c + FIRST + 222, S_DOUT, 1); lit(c + FIRST + 223, S_DOUT, 0);
    lit(c + FIRST + 235, S_DOUT, 1); lit(c + FIRST + 236, S_DOUT, 0);
    lit(c + FIRST + 239, S_DOUT, 0); lit(c + FIRST + 240, S_DOUT, 1);
    lit(c + FIRST + 245, S_DOUT, 1); lit(c + FIRST + 246, S_DOUT, 0);
    lit(c + 505, S_RECNT, 4);
    wait_until(c + FR + 5);

    // Pending start: two extra pulses during SEND give exactly one more frame.
    ram[4] = 24'hA5A5A5; ram[5] = 24'h5A5A5A;
    pulse_start(c);
    wait_until(c + 50);
    pulse_start(c2);
    wait_until(c + 100);
    pulse_start(c2);
    lit(c + 502, S_DONE, 1); lit(c + 503, S_BUSY, 1);
    lit(c + 504, S_RE, 1); lit(c + 504, S_ADDR, 4);
    lit(c + 503 + FIRST, S_DOUT, 1);
    lit(c + 1005, S_DONE, 1); lit(c + 1006, S_BUSY, 0);
    lit(c + 1600, S_BUSY, 0); lit(c + 1600, S_RECNT, 8);
    wait_until(c + 1601);

    // Reset at bit 10 of pixel 0 (bit index 13 of the frame).
    ram[4] = 24'h123456; ram[5] = 24'hABCDEF;
    pulse_start(c);
    r = c + FIRST + 13 * TB + 2;
    wait_until(r);
    rst = 1'b1;
    model_reset(r);
    lit(r + 1, S_DOUT, 0); lit(r + 1, S_BUSY, 0); lit(r + 1, S_RE, 0);
    lit(r + 1, S_STATE, 32'(ST_IDLE));
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_until(c + FR + 100);
    pulse_start(c);
    wait_until(c + FR + 5);

    // Random images.
    for (int n = 0; n < 50; n++) begin
      ram[4] = 24'($urandom_range(32'h00FF_FFFF, 0));
      ram[5] = 24'($urandom_range(32'h00FF_FFFF, 0));
      pulse_start(c);
      wait_until(c + FR + 2 + int'($urandom_range(3, 0)));
    end

    end_req = 1'b1;
    wait_until(cyc + 3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
